// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, opcode-enum encodings and constants for the integer execute stage.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_LEN   = 32;
  localparam int unsigned ADDR_LEN   = 32;
  localparam int unsigned ROB_LEN    = 4;
  localparam int unsigned OPENUM_LEN = 6;

  localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
  localparam logic [ROB_LEN:0]    ZERO_ROB  = '0;
  localparam logic                TRUE      = 1'b1;
  localparam logic                FALSE     = 1'b0;

  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP   = 6'd0;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LUI   = 6'd1;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AUIPC = 6'd2;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JAL   = 6'd3;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JALR  = 6'd4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BEQ   = 6'd5;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BNE   = 6'd6;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLT   = 6'd7;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGE   = 6'd8;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLTU  = 6'd9;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGEU  = 6'd10;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADD   = 6'd11;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SUB   = 6'd12;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLL   = 6'd13;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLT   = 6'd14;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTU  = 6'd15;
  localparam logic [OPENUM_LEN-1:0] OPENUM_XOR   = 6'd16;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRL   = 6'd17;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRA   = 6'd18;
  localparam logic [OPENUM_LEN-1:0] OPENUM_OR    = 6'd19;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AND   = 6'd20;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI  = 6'd21;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTI  = 6'd22;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLTIU = 6'd23;
  localparam logic [OPENUM_LEN-1:0] OPENUM_XORI  = 6'd24;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ORI   = 6'd25;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ANDI  = 6'd26;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SLLI  = 6'd27;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRLI  = 6'd28;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SRAI  = 6'd29;

endpackage

// File: rtl/alu_comb.sv
// Pure combinational RV32I ALU/branch/jump evaluation: result, taken flag and next pc.
module alu_comb
  import alu_exec_unit_pkg::*;
(
  input  logic [OPENUM_LEN-1:0] openum,
  input  logic [DATA_LEN-1:0]   v1,
  input  logic [DATA_LEN-1:0]   v2,
  input  logic [ADDR_LEN-1:0]   pc,
  input  logic [DATA_LEN-1:0]   imm,
  output logic [DATA_LEN-1:0]   result,
  output logic                  jump,
  output logic [ADDR_LEN-1:0]   target
);

  logic [ADDR_LEN-1:0] pc_plus4;
  logic [ADDR_LEN-1:0] pc_plus_imm;
  logic                br_cond;
  logic                is_branch;

  assign pc_plus4    = pc + ADDR_LEN'(4);
  assign pc_plus_imm = pc + imm;

  always_comb begin
    result    = ZERO_WORD;
    jump      = FALSE;
    target    = pc_plus4;
    br_cond   = FALSE;
    is_branch = FALSE;
    case (openum)
      OPENUM_LUI:   result = imm;
      OPENUM_AUIPC: result = pc_plus_imm;
      OPENUM_ADD:   result = v1 + v2;
      OPENUM_ADDI:  result = v1 + imm;
      OPENUM_SUB:   result = v1 - v2;
      OPENUM_AND:   result = v1 & v2;
      OPENUM_ANDI:  result = v1 & imm;
      OPENUM_OR:    result = v1 | v2;
      OPENUM_ORI:   result = v1 | imm;
      OPENUM_XOR:   result = v1 ^ v2;
      OPENUM_XORI:  result = v1 ^ imm;
      OPENUM_SLL:   result = v1 << v2[4:0];
      OPENUM_SLLI:  result = v1 << imm[4:0];
      OPENUM_SRL:   result = v1 >> v2[4:0];
      OPENUM_SRLI:  result = v1 >> imm[4:0];
      OPENUM_SRA:   result = $unsigned($signed(v1) >>> v2[4:0]);
      OPENUM_SRAI:  result = $unsigned($signed(v1) >>> imm[4:0]);
      OPENUM_SLT:   result = {{(DATA_LEN-1){1'b0}}, $signed(v1) < $signed(v2)};
      OPENUM_SLTI:  result = {{(DATA_LEN-1){1'b0}}, $signed(v1) < $signed(imm)};
      OPENUM_SLTU:  result = {{(DATA_LEN-1){1'b0}}, v1 < v2};
      OPENUM_SLTIU: result = {{(DATA_LEN-1){1'b0}}, v1 < imm};
      OPENUM_JAL: begin
        result = pc_plus4;
        jump   = TRUE;
        target = pc_plus_imm;
      end
      OPENUM_JALR: begin
        result = pc_plus4;
        jump   = TRUE;
        target = (v1 + imm) & ~ADDR_LEN'(1);
      end
      OPENUM_BEQ:  begin is_branch = TRUE; br_cond = (v1 == v2); end
      OPENUM_BNE:  begin is_branch = TRUE; br_cond = (v1 != v2); end
      OPENUM_BLT:  begin is_branch = TRUE; br_cond = ($signed(v1) < $signed(v2)); end
      OPENUM_BGE:  begin is_branch = TRUE; br_cond = ($signed(v1) >= $signed(v2)); end
      OPENUM_BLTU: begin is_branch = TRUE; br_cond = (v1 < v2); end
      OPENUM_BGEU: begin is_branch = TRUE; br_cond = (v1 >= v2); end
      // Unknown encodings fall through to result 0 / not taken so the ROB can still retire.
      default: ;
    endcase
    if (is_branch) begin
      jump   = br_cond;
      target = br_cond ? pc_plus_imm : pc_plus4;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: issue detect, rollback gating and a single registered CDB beat.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rollback,
  input  logic [OPENUM_LEN-1:0] openum_in,
  input  logic [DATA_LEN-1:0]   V1_in,
  input  logic [DATA_LEN-1:0]   V2_in,
  input  logic [ADDR_LEN-1:0]   pc_in,
  input  logic [DATA_LEN-1:0]   imm_in,
  input  logic [ROB_LEN:0]      rob_id_in,
  output logic                  cdb_valid,
  output logic [ROB_LEN:0]      cdb_rob_id,
  output logic [DATA_LEN-1:0]   cdb_result,
  output logic                  cdb_jump,
  output logic [ADDR_LEN-1:0]   cdb_target_pc
);

  logic [DATA_LEN-1:0] alu_result;
  logic                alu_jump;
  logic [ADDR_LEN-1:0] alu_target;
  logic                issue;

  logic                valid_q;
  logic [ROB_LEN:0]    rob_id_q;
  logic [DATA_LEN-1:0] result_q;
  logic                jump_q;
  logic [ADDR_LEN-1:0] target_q;

  alu_comb u_alu_comb (
    .openum (openum_in),
    .v1     (V1_in),
    .v2     (V2_in),
    .pc     (pc_in),
    .imm    (imm_in),
    .result (alu_result),
    .jump   (alu_jump),
    .target (alu_target)
  );

  // Tag 0 means "no ROB entry", so a real op with tag 0 is not an issue.
  assign issue = (openum_in != OPENUM_NOP) && (rob_id_in != ZERO_ROB);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= FALSE;
      rob_id_q <= ZERO_ROB;
      result_q <= ZERO_WORD;
      jump_q   <= FALSE;
      target_q <= '0;
    end else if (rollback) begin
      valid_q <= FALSE;
    end else if (issue) begin
      valid_q  <= TRUE;
      rob_id_q <= rob_id_in;
      result_q <= alu_result;
      jump_q   <= alu_jump;
      target_q <= alu_target;
    end else begin
      valid_q <= FALSE;
    end
  end

  assign cdb_valid     = valid_q;
  assign cdb_rob_id    = rob_id_q;
  assign cdb_result    = result_q;
  assign cdb_jump      = jump_q;
  assign cdb_target_pc = target_q;

endmodule
